mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter for the single-port unified memory shared by the fetch stage and the EX/MEM stage of the pipelined datapath. It accepts fetch requests from the PC path and load/store requests from the EX/MEM register outputs, serialises them onto one request/ready memory port, and drives the stall signals that freeze the PC, IF/ID, ID/EX and EX/MEM registers while an access is outstanding. A timeout counter guarantees the pipeline never deadlocks on a silent memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, cycles in an access state without mem_ready before abort; 0 disables the timeout
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until the if_valid cycle
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_valid  out  1  one-cycle pulse, if_rdata valid
- stall_if  out  1  hold PC and IF/ID this cycle
- dm_read  in  1  load, from EX/MEM memread_out
- dm_write  in  1  store, from EX/MEM memwrite_out
- dm_addr  in  ADDR_W  from EX/MEM alu_result_out
- dm_wdata  in  DATA_W  from EX/MEM read_data2_out
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  one-cycle pulse, load/store complete
- stall_mem  out  1  freeze PC through EX/MEM, bubble into MEM/WB
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  access complete; sampled only while mem_req=1
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, DATA, DDONE, FETCH, FDONE.
- IDLE: if dm_read|dm_write -> DATA, load mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_write, mem_req=1. Else if if_req -> FETCH, mem_addr=if_addr, mem_we=0, mem_req=1. Else stay, mem_req=0.
- Priority: data over fetch (older instruction). No preemption: an in-flight FETCH finishes before a pending data access is issued.
- dm_read and dm_write both high: treated as a write.
- DATA/FETCH: mem_addr/mem_we/mem_wdata held stable. When mem_ready=1, capture mem_rdata into dm_rdata (loads only; stores leave dm_rdata unchanged) or if_rdata, clear mem_req, and go to DDONE/FDONE.
- Timeout: counter cleared on entry to DATA/FETCH and incremented each cycle without mem_ready. If it reaches TIMEOUT, clear mem_req, set bus_err, load 0 into the destination rdata, and go to DDONE/FDONE.
- DDONE: dm_valid=1 -> IDLE. FDONE: if_valid=1 -> IDLE.
- stall_mem = (dm_read|dm_write) && state!=DDONE. Combinational.
- stall_if = (if_req && state!=FDONE) || stall_mem. Combinational.

## Timing
- Reset (reset=0 at an edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0, counter=0, bus_err=0.
- Reset applies mid-access as well: mem_req drops the next edge and no completion pulse is issued.
- Minimum latency with mem_ready in the first request cycle: request cycle (IDLE) -> DATA/FETCH -> DONE. Three cycles, stall asserted for two, pipeline advances on the edge that ends the DONE cycle.
- Each wait cycle of mem_ready adds one cycle.
- mem_ready while mem_req=0 is ignored.
- Timeout abort occurs on the edge that ends the TIMEOUT-th access cycle without ready, i.e. DONE is entered after TIMEOUT cycles in the access state.
- mem_ready high in the same cycle the counter reaches TIMEOUT counts as success; bus_err stays unchanged.
- DDONE/FDONE always return to IDLE, so back-to-back accesses are separated by one IDLE cycle.

## Test plan
- Load, dm_read=1, dm_addr=0x40, mem_ready=1 in first DATA cycle, mem_rdata=0xDEADBEEF -> mem_req high 1 cycle with mem_addr=0x40, mem_we=0; dm_valid pulse with dm_rdata=0xDEADBEEF; stall_mem high exactly 2 cycles.
- Store, dm_write=1, dm_addr=0x80, dm_wdata=0x12345678, mem_ready delayed 3 cycles -> mem_we=1 and address/data stable for 4 cycles; dm_valid 1 cycle later; dm_rdata unchanged.
- if_req and dm_read asserted together in IDLE -> DATA served first with stall_if high throughout; FETCH follows after one IDLE cycle; if_valid delivers mem_rdata.
- dm_read arrives during FETCH -> fetch completes with if_valid; stall_mem stays high; data access issued after the IDLE cycle.
- TIMEOUT=4, mem_ready never asserted on a load -> DDONE after 4 DATA cycles; dm_rdata=0; bus_err=1 and held across later successful accesses until reset.
- reset=0 during DATA wait -> next cycle mem_req=0, state IDLE, no dm_valid, bus_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sequencer/arbiter for fetch and load/store traffic
// Data beats fetch when both are idle-pending; a started access always runs to DONE or timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_DDONE = 3'd2,
    S_FETCH = 3'd3,
    S_FDONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              bus_err_q,   bus_err_d;

  logic dm_any;
  logic ready_hit;
  logic timed_out;

  // mem_ready only counts while a request is actually on the port.
  assign dm_any    = dm_read | dm_write;
  assign ready_hit = mem_req_q & mem_ready;
  assign timed_out = TIMEOUT_EN & ~ready_hit & (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dm_any) begin
          state_d = S_DATA;
        end else if (if_req) begin
          state_d = S_FETCH;
        end
      end
      S_DATA: begin
        if (ready_hit || timed_out) begin
          state_d = S_DDONE;
        end
      end
      S_FETCH: begin
        if (ready_hit || timed_out) begin
          state_d = S_FDONE;
        end
      end
      S_DDONE: state_d = S_IDLE;
      S_FDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dm_valid  = (state_q == S_DDONE);
    if_valid  = (state_q == S_FDONE);
    stall_mem = dm_any && (state_q != S_DDONE);
    stall_if  = (if_req && (state_q != S_FDONE)) || stall_mem;
  end

  // Port registers and captured read data; address/we/wdata stay frozen during an access.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (dm_any) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = '0;
        end else if (if_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          cnt_d      = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_DATA: begin
        if (ready_hit) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = '0;
          end
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        if (ready_hit) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
        end else if (timed_out) begin
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          if_rdata_d = '0;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule
